// File: rtl/mpmc9_wdf_burst_seq.sv
// mpmc9_wdf_burst_seq
// Write-data burst sequencer for the MIG write data FIFO (app_wdf_*).
// When the controller state machine sits in WRITE_DATA0, a cache line and its
// byte selects are latched, split into BEATS beats of DATA_W bits and strobed
// into the FIFO under app_wdf_rdy. A one-cycle wdone pulse marks the last beat
// accepted.
//
// Optional feature: define MPMC9_WDF_WATCHDOG_EN to build a stall watchdog that
// sets the sticky wd_timeout flag after TIMEOUT rdy-low cycles in SEND. Without
// the macro, wd_timeout is tied to 0.
//
// Ports
//   clk         in   controller clock, all logic on posedge
//   rst         in   synchronous active-high reset
//   state       in   controller state (mpmc9_pkg encoding)
//   line_i      in   write line, beat n = line_i[n*DATA_W +: DATA_W]
//   sel_i       in   byte enables, 1 = write byte
//   rdy         in   app_wdf_rdy
//   wren        out  app_wdf_wren
//   wend        out  app_wdf_end
//   wdata       out  app_wdf_data
//   wmask       out  app_wdf_mask, 1 = byte not written
//   wdone       out  one-cycle pulse, last beat accepted
//   wd_timeout  out  sticky stall flag
//
// FSM states
//   IDLE | waiting for state == WRITE_DATA0
//   SEND | beats presented on app_wdf_*, advancing on wren && rdy
//   HOLD | burst done, waiting for the controller to leave WRITE_DATA0

module mpmc9_wdf_burst_seq #(
    parameter int          DATA_W      = 128,
    parameter int          BEATS       = 2,
    parameter int          TIMEOUT     = 1023,
    parameter logic [3:0]  WRITE_DATA0 = 4'd5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3:0]                state,
    input  logic [BEATS*DATA_W-1:0]   line_i,
    input  logic [BEATS*DATA_W/8-1:0] sel_i,
    input  logic                      rdy,
    output logic                      wren,
    output logic                      wend,
    output logic [DATA_W-1:0]         wdata,
    output logic [DATA_W/8-1:0]       wmask,
    output logic                      wdone,
    output logic                      wd_timeout
);

    localparam int MASK_W = DATA_W / 8;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } fsm_t;

    fsm_t                      fsm, fsm_next;
    logic [BEAT_W-1:0]         beat, beat_next;
    logic                      wren_next, wend_next, wdone_next;
    logic [DATA_W-1:0]         wdata_next;
    logic [MASK_W-1:0]         wmask_next;
    logic [BEATS*DATA_W-1:0]   line_q;
    logic [BEATS*MASK_W-1:0]   sel_q;
    logic                      start;
    logic                      accept;

    assign start  = (fsm == IDLE) && (state == WRITE_DATA0);
    assign accept = wren && rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm   <= IDLE;
            beat  <= '0;
            wren  <= 1'b0;
            wend  <= 1'b0;
            wdata <= '0;
            wmask <= '1;
            wdone <= 1'b0;
        end else begin
            fsm   <= fsm_next;
            beat  <= beat_next;
            wren  <= wren_next;
            wend  <= wend_next;
            wdata <= wdata_next;
            wmask <= wmask_next;
            wdone <= wdone_next;
        end
    end

    // Line storage needs no reset: it is only read while SEND, which is
    // always preceded by a latch.
    always_ff @(posedge clk) begin
        if (start) begin
            line_q <= line_i;
            sel_q  <= sel_i;
        end
    end

    always_comb begin
        fsm_next   = fsm;
        beat_next  = beat;
        wren_next  = wren;
        wend_next  = wend;
        wdata_next = wdata;
        wmask_next = wmask;
        wdone_next = 1'b0;
        case (fsm)
            IDLE: begin
                if (start) begin
                    // beat 0 comes straight from the inputs so wren rises one
                    // cycle after entry
                    wdata_next = line_i[DATA_W-1:0];
                    wmask_next = ~sel_i[MASK_W-1:0];
                    wren_next  = 1'b1;
                    wend_next  = (BEATS == 1);
                    beat_next  = '0;
                    fsm_next   = SEND;
                end
            end
            SEND: begin
                // leaving WRITE_DATA0 here is ignored: MIG needs whole bursts
                if (accept) begin
                    if (beat == LAST_BEAT) begin
                        wren_next  = 1'b0;
                        wend_next  = 1'b0;
                        wdone_next = 1'b1;
                        fsm_next   = HOLD;
                    end else begin
                        beat_next  = beat + 1'b1;
                        wdata_next = line_q[beat_next*DATA_W +: DATA_W];
                        wmask_next = ~sel_q[beat_next*MASK_W +: MASK_W];
                        wend_next  = (beat_next == LAST_BEAT);
                    end
                end
            end
            HOLD: begin
                if (state != WRITE_DATA0) begin
                    fsm_next = IDLE;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

`ifdef MPMC9_WDF_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] stall_cnt;

    // Counter is zero outside SEND, which covers the clear on SEND entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            wd_timeout <= 1'b0;
        end else if (fsm != SEND || rdy) begin
            stall_cnt <= '0;
        end else begin
            if (stall_cnt != CNT_W'(TIMEOUT)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (stall_cnt == CNT_W'(TIMEOUT - 1)) begin
                wd_timeout <= 1'b1;
            end
        end
    end
`else
    assign wd_timeout = 1'b0;
`endif

endmodule
